// File: rtl/cva6_accel_req_buffer_if.sv
// Dispatcher/accelerator handshake bundle for cva6_accel_req_buffer.
// Perf counter signals exist only when CVA6_ACCEL_BUF_PERF_EN is defined.
interface cva6_accel_req_buffer_if #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned TRANS_ID_W = 3
);
    logic                  flush_i;

    logic                  up_valid_i;
    logic                  up_ready_o;
    logic [31:0]           up_insn_i;
    logic [XLEN-1:0]       up_rs1_i;
    logic [XLEN-1:0]       up_rs2_i;
    logic [TRANS_ID_W-1:0] up_trans_id_i;

    logic                  acc_req_valid_o;
    logic                  acc_req_ready_i;
    logic [31:0]           acc_req_insn_o;
    logic [XLEN-1:0]       acc_req_rs1_o;
    logic [XLEN-1:0]       acc_req_rs2_o;
    logic [TRANS_ID_W-1:0] acc_req_trans_id_o;

    logic                  acc_resp_valid_i;
    logic                  acc_resp_ready_o;
    logic [XLEN-1:0]       acc_resp_result_i;
    logic [TRANS_ID_W-1:0] acc_resp_trans_id_i;
    logic                  acc_resp_error_i;

    logic                  resp_valid_o;
    logic                  resp_ready_i;
    logic [XLEN-1:0]       resp_result_o;
    logic [TRANS_ID_W-1:0] resp_trans_id_o;
    logic                  resp_error_o;

    logic                  spurious_o;
    logic                  idle_o;
`ifdef CVA6_ACCEL_BUF_PERF_EN
    logic [31:0]           perf_full_cycles_o;
    logic [31:0]           perf_throttle_cycles_o;
`endif

    // Buffer side.
    modport slave (
        input  flush_i, up_valid_i, up_insn_i, up_rs1_i, up_rs2_i, up_trans_id_i,
        input  acc_req_ready_i,
        input  acc_resp_valid_i, acc_resp_result_i, acc_resp_trans_id_i, acc_resp_error_i,
        input  resp_ready_i,
        output up_ready_o,
        output acc_req_valid_o, acc_req_insn_o, acc_req_rs1_o, acc_req_rs2_o,
        output acc_req_trans_id_o,
        output acc_resp_ready_o,
        output resp_valid_o, resp_result_o, resp_trans_id_o, resp_error_o,
`ifdef CVA6_ACCEL_BUF_PERF_EN
        output perf_full_cycles_o, perf_throttle_cycles_o,
`endif
        output spurious_o, idle_o
    );

    // Dispatcher + accelerator side.
    modport master (
        output flush_i, up_valid_i, up_insn_i, up_rs1_i, up_rs2_i, up_trans_id_i,
        output acc_req_ready_i,
        output acc_resp_valid_i, acc_resp_result_i, acc_resp_trans_id_i, acc_resp_error_i,
        output resp_ready_i,
        input  up_ready_o,
        input  acc_req_valid_o, acc_req_insn_o, acc_req_rs1_o, acc_req_rs2_o,
        input  acc_req_trans_id_o,
        input  acc_resp_ready_o,
        input  resp_valid_o, resp_result_o, resp_trans_id_o, resp_error_o,
`ifdef CVA6_ACCEL_BUF_PERF_EN
        input  perf_full_cycles_o, perf_throttle_cycles_o,
`endif
        input  spurious_o, idle_o
    );
endinterface

// File: rtl/cva6_accel_req_buffer.sv
// Request FIFO with outstanding-request cap and registered response path between the
// CVA6 accelerator dispatcher and the accelerator port. Optional: CVA6_ACCEL_BUF_PERF_EN.
module cva6_accel_req_buffer #(
    parameter int unsigned XLEN            = 64,
    parameter int unsigned TRANS_ID_W      = 3,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    cva6_accel_req_buffer_if.slave        bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]           insn_q  [DEPTH];
    logic [XLEN-1:0]       rs1_q   [DEPTH];
    logic [XLEN-1:0]       rs2_q   [DEPTH];
    logic [TRANS_ID_W-1:0] id_q    [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [OutW-1:0] outst_q, outst_d;
    logic            spurious_q, spurious_d;

    logic                  resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]       resp_result_q;
    logic [TRANS_ID_W-1:0] resp_id_q;
    logic                  resp_error_q;

    logic push, issue, accept;

    assign bus.up_ready_o      = (count_q != CntW'(DEPTH));
    assign bus.acc_req_valid_o = (count_q != '0) && (outst_q < OutW'(MAX_OUTSTANDING))
                                 && !bus.flush_i;
    assign bus.acc_req_insn_o     = insn_q[rd_ptr_q];
    assign bus.acc_req_rs1_o      = rs1_q[rd_ptr_q];
    assign bus.acc_req_rs2_o      = rs2_q[rd_ptr_q];
    assign bus.acc_req_trans_id_o = id_q[rd_ptr_q];

    assign bus.acc_resp_ready_o = !resp_valid_q || bus.resp_ready_i;
    assign bus.resp_valid_o     = resp_valid_q;
    assign bus.resp_result_o    = resp_result_q;
    assign bus.resp_trans_id_o  = resp_id_q;
    assign bus.resp_error_o     = resp_error_q;
    assign bus.spurious_o       = spurious_q;
    assign bus.idle_o           = (count_q == '0) && (outst_q == '0) && !resp_valid_q;

    assign push   = bus.up_valid_i && bus.up_ready_o && !bus.flush_i;
    assign issue  = bus.acc_req_valid_o && bus.acc_req_ready_i;
    assign accept = bus.acc_resp_valid_i && bus.acc_resp_ready_o;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        outst_d      = outst_q;
        spurious_d   = spurious_q;
        resp_valid_d = resp_valid_q;

        if (bus.flush_i) begin
            // Flush suppresses both push and issue, so wr_ptr is already final.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (issue) rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push && !issue) count_d = count_q + CntW'(1);
            else if (!push && issue) count_d = count_q - CntW'(1);
        end

        if (accept && (outst_q == '0)) spurious_d = 1'b1;
        if (issue && !accept) outst_d = outst_q + OutW'(1);
        else if (accept && !issue && (outst_q != '0)) outst_d = outst_q - OutW'(1);

        if (accept) resp_valid_d = 1'b1;
        else if (bus.resp_ready_i) resp_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            outst_q      <= '0;
            spurious_q   <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            outst_q      <= outst_d;
            spurious_q   <= spurious_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count/valid flags.
    always_ff @(posedge clk_i) begin
        if (push) begin
            insn_q[wr_ptr_q] <= bus.up_insn_i;
            rs1_q[wr_ptr_q]  <= bus.up_rs1_i;
            rs2_q[wr_ptr_q]  <= bus.up_rs2_i;
            id_q[wr_ptr_q]   <= bus.up_trans_id_i;
        end
        if (accept) begin
            resp_result_q <= bus.acc_resp_result_i;
            resp_id_q     <= bus.acc_resp_trans_id_i;
            resp_error_q  <= bus.acc_resp_error_i;
        end
    end

`ifdef CVA6_ACCEL_BUF_PERF_EN
    logic [31:0] perf_full_q, perf_throttle_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_full_q     <= '0;
            perf_throttle_q <= '0;
        end else begin
            if (bus.up_valid_i && !bus.up_ready_o) perf_full_q <= perf_full_q + 32'd1;
            if ((count_q != '0) && (outst_q == OutW'(MAX_OUTSTANDING))) begin
                perf_throttle_q <= perf_throttle_q + 32'd1;
            end
        end
    end

    assign bus.perf_full_cycles_o     = perf_full_q;
    assign bus.perf_throttle_cycles_o = perf_throttle_q;
`endif
endmodule

// File: tb/tb_cva6_accel_req_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_cva6_accel_req_buffer;
    localparam int unsigned XLEN = 64;
    localparam int unsigned TIDW = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO = 8;

    typedef struct {
        logic [31:0]     insn;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [TIDW-1:0] id;
    } entry_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    cva6_accel_req_buffer_if #(.XLEN(XLEN), .TRANS_ID_W(TIDW)) bus ();

    cva6_accel_req_buffer #(
        .XLEN(XLEN), .TRANS_ID_W(TIDW), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    entry_t          q[$];
    int              outst;
    logic            r_valid, r_err, spur;
    logic [XLEN-1:0] r_result;
    logic [TIDW-1:0] r_id;
    int unsigned     perf_full, perf_thr;

    // Stimulus for the next cycle.
    logic            s_flush, s_uv, s_areq_rdy, s_arsp_v, s_rrdy, s_err;
    entry_t          s_e;
    logic [XLEN-1:0] s_result;
    logic [TIDW-1:0] s_rid;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_stim();
        s_flush = 0; s_uv = 0; s_areq_rdy = 0; s_arsp_v = 0; s_rrdy = 0; s_err = 0;
        s_e.insn = '0; s_e.rs1 = '0; s_e.rs2 = '0; s_e.id = '0;
        s_result = '0; s_rid = '0;
    endtask

    task automatic drive();
        bus.flush_i             = s_flush;
        bus.up_valid_i          = s_uv;
        bus.up_insn_i           = s_e.insn;
        bus.up_rs1_i            = s_e.rs1;
        bus.up_rs2_i            = s_e.rs2;
        bus.up_trans_id_i       = s_e.id;
        bus.acc_req_ready_i     = s_areq_rdy;
        bus.acc_resp_valid_i    = s_arsp_v;
        bus.acc_resp_result_i   = s_result;
        bus.acc_resp_trans_id_i = s_rid;
        bus.acc_resp_error_i    = s_err;
        bus.resp_ready_i        = s_rrdy;
    endtask

    task automatic model_clear();
        q.delete();
        outst = 0; r_valid = 0; spur = 0; perf_full = 0; perf_thr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        clear_stim();
        drive();
        #1;
        model_clear();
        check_eq("rst_up_ready", 64'(bus.up_ready_o), 64'd1);
        check_eq("rst_acc_req_valid", 64'(bus.acc_req_valid_o), 64'd0);
        check_eq("rst_acc_resp_ready", 64'(bus.acc_resp_ready_o), 64'd1);
        check_eq("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        check_eq("rst_spurious", 64'(bus.spurious_o), 64'd0);
        check_eq("rst_idle", 64'(bus.idle_o), 64'd1);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // One cycle: apply stimulus, compare every output with the model, advance the model.
    task automatic tick();
        logic exp_up_rdy, exp_areq_v, exp_arsp_rdy, push, issue, accept;
        @(negedge clk_i);
        drive();
        #1;
        exp_up_rdy   = (q.size() != DEPTH);
        exp_areq_v   = (q.size() != 0) && (outst < MAXO) && !s_flush;
        exp_arsp_rdy = !r_valid || s_rrdy;
        push   = s_uv && exp_up_rdy && !s_flush;
        issue  = exp_areq_v && s_areq_rdy;
        accept = s_arsp_v && exp_arsp_rdy;

        check_eq("up_ready", 64'(bus.up_ready_o), 64'(exp_up_rdy));
        check_eq("acc_req_valid", 64'(bus.acc_req_valid_o), 64'(exp_areq_v));
        if (q.size() != 0) begin
            check_eq("acc_req_insn", 64'(bus.acc_req_insn_o), 64'(q[0].insn));
            check_eq("acc_req_rs1", bus.acc_req_rs1_o, q[0].rs1);
            check_eq("acc_req_rs2", bus.acc_req_rs2_o, q[0].rs2);
            check_eq("acc_req_id", 64'(bus.acc_req_trans_id_o), 64'(q[0].id));
        end
        check_eq("acc_resp_ready", 64'(bus.acc_resp_ready_o), 64'(exp_arsp_rdy));
        check_eq("resp_valid", 64'(bus.resp_valid_o), 64'(r_valid));
        if (r_valid) begin
            check_eq("resp_result", bus.resp_result_o, r_result);
            check_eq("resp_id", 64'(bus.resp_trans_id_o), 64'(r_id));
            check_eq("resp_error", 64'(bus.resp_error_o), 64'(r_err));
        end
        check_eq("spurious", 64'(bus.spurious_o), 64'(spur));
        check_eq("idle", 64'(bus.idle_o), 64'(q.size() == 0 && outst == 0 && !r_valid));
`ifdef CVA6_ACCEL_BUF_PERF_EN
        check_eq("perf_full", 64'(bus.perf_full_cycles_o), 64'(perf_full));
        check_eq("perf_throttle", 64'(bus.perf_throttle_cycles_o), 64'(perf_thr));
`endif
        @(posedge clk_i);
        if (s_uv && !exp_up_rdy) perf_full++;
        if (q.size() != 0 && outst == MAXO) perf_thr++;
        if (s_flush) q.delete();
        else begin
            if (issue) void'(q.pop_front());
            if (push) q.push_back(s_e);
        end
        if (accept && outst == 0) spur = 1;
        if (issue && !accept) outst++;
        else if (accept && !issue && outst > 0) outst--;
        if (accept) begin
            r_valid = 1; r_result = s_result; r_id = s_rid; r_err = s_err;
        end else if (s_rrdy) r_valid = 0;
    endtask

    task automatic set_push(input int id);
        s_uv = 1;
        s_e.insn = 32'h0000_500B + 32'(id << 12);
        s_e.rs1 = 64'(id) * 64'h1111; s_e.rs2 = ~64'(id); s_e.id = TIDW'(id);
    endtask

    initial begin
        clear_stim();
        drive();
        do_reset();

        // Single request round trip.
        s_uv = 1; s_e.insn = 32'h0000_500B; s_e.rs1 = 64'd1; s_e.rs2 = 64'd2; s_e.id = 3;
        s_areq_rdy = 1; tick();
        s_uv = 0; tick();
        s_arsp_v = 1; s_result = 64'hAB; s_rid = 3; tick();
        s_arsp_v = 0; s_rrdy = 1; tick();
        tick();

        // Backpressure: five pushes into a four-entry FIFO, then drain in order.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_push(i); tick();
        end
        s_uv = 0; tick();
        s_areq_rdy = 1;
        repeat (6) tick();

        // Outstanding cap.
        do_reset();
        s_areq_rdy = 1;
        for (int i = 0; i < 9; i++) begin
            set_push(i); tick();
        end
        s_uv = 0; repeat (3) tick();
        s_arsp_v = 1; s_rid = 0; s_result = 64'h55; s_rrdy = 1; tick();
        s_arsp_v = 0; repeat (2) tick();

        // Flush with one request in flight.
        do_reset();
        set_push(1); s_areq_rdy = 1; tick();
        s_uv = 0; tick();
        s_areq_rdy = 0;
        for (int i = 2; i < 5; i++) begin
            set_push(i); tick();
        end
        s_flush = 1; set_push(7); tick();
        s_flush = 0; s_uv = 0; tick();
        s_arsp_v = 1; s_rid = 1; s_rrdy = 1; tick();
        s_arsp_v = 0; repeat (2) tick();

        // Held response under resp_ready_i low, then same-cycle replace.
        do_reset();
        s_areq_rdy = 1; set_push(5); tick();
        set_push(6); tick();
        s_uv = 0; repeat (2) tick();
        s_arsp_v = 1; s_rid = 5; s_result = 64'h5555; tick();
        s_rid = 6; s_result = 64'h6666; s_err = 1;
        repeat (10) tick();
        s_rrdy = 1; tick();
        s_arsp_v = 0; repeat (2) tick();

        // Spurious response.
        do_reset();
        s_arsp_v = 1; s_rid = 2; s_rrdy = 1; tick();
        s_arsp_v = 0; repeat (3) tick();

        // Random traffic with a mid-run reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            s_flush    = ($urandom_range(99) < 3);
            s_uv       = ($urandom_range(99) < 60);
            s_e.insn   = $urandom;
            s_e.rs1    = {$urandom, $urandom};
            s_e.rs2    = {$urandom, $urandom};
            s_e.id     = TIDW'($urandom);
            s_areq_rdy = ($urandom_range(99) < 60);
            s_arsp_v   = (outst > 0) ? ($urandom_range(99) < 40) : ($urandom_range(999) < 3);
            s_result   = {$urandom, $urandom};
            s_rid      = TIDW'($urandom);
            s_err      = ($urandom_range(99) < 10);
            s_rrdy     = ($urandom_range(99) < 60);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
